// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin packet stream multiplexer.
package rr_mux_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Increment an index and wrap it back to 0 at n.
    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        found = |req;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= N_VAL) begin
                sum = sum - N_VAL;
            end
            cand = sum[ID_W-1:0];
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_packet_stream_mux.sv
// N_REQ valid/ready streams share one registered output; round-robin arbitration
// happens only between packets, so a winner owns the output until its last beat.
module rr_packet_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          in_valid,
    output logic [N_REQ-1:0]          in_ready,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    input  logic [N_REQ-1:0]          in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [ID_W-1:0]           out_src
);

    arb_state_e      state_reg;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] owner_reg;
    logic            run_reg;
    logic            out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic            out_last_reg;
    logic [ID_W-1:0] out_src_reg;

    logic              load_en;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   sel_idx;
    logic              sel_ok;
    logic              accept;
    logic              acc_last;
    logic [DATA_W-1:0] data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign load_en = !out_valid_reg || out_ready;

    // run_reg keeps every in_ready low through reset and the first cycle after it.
    always_comb begin
        sel_idx  = (state_reg == LOCK) ? owner_reg : pick_idx;
        sel_ok   = run_reg && load_en && ((state_reg == LOCK) || pick_found);
        in_ready = '0;
        if (sel_ok) begin
            in_ready[sel_idx] = 1'b1;
        end
        accept   = sel_ok && in_valid[sel_idx];
        acc_last = in_last[sel_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ARB;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            run_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
        end else begin
            run_reg <= 1'b1;
            if (load_en) begin
                out_valid_reg <= accept;
            end
            if (accept) begin
                out_data_reg <= data_arr[sel_idx];
                out_last_reg <= acc_last;
                out_src_reg  <= sel_idx;
                if (acc_last) begin
                    ptr_reg   <= ID_W'(mod_inc(32'(sel_idx), N_REQ));
                    state_reg <= ARB;
                end else begin
                    owner_reg <= sel_idx;
                    state_reg <= LOCK;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_rr_packet_stream_mux.sv
// Randomized scoreboard bench for rr_packet_stream_mux against a packet-level model.
module tb_rr_packet_stream_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]  in_last = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [IW-1:0] out_src;

    always #5 clk = ~clk;

    rr_packet_stream_mux #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] src;
    } exp_t;

    beat_t src_q [N][$];
    exp_t  sb [$];

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the output (-1 = nobody), where round-robin resumes,
    // and whether the output register holds an unconsumed beat.
    int   m_ptr   = 0;
    int   m_owner = -1;
    bit   m_ovalid = 0;
    int   valid_pct = 100;
    int   ready_pct = 100;
    bit   refill = 0;
    bit   first_after_rst = 0;
    logic [DW-1:0] seq = 8'h10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_packet(input int r, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = seq;
            b.last = (k == len - 1);
            seq    = seq + 8'd1;
            src_q[r].push_back(b);
        end
    endtask

    task automatic run_cycles(input int n);
        logic [N-1:0] exp_rdy;
        bit   load_en;
        bit   acc;
        int   sel;
        beat_t b;
        exp_t  e;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (refill && src_q[i].size() < 6) begin
                    add_packet(i, $urandom_range(1, 4));
                end
                in_valid[i] = (src_q[i].size() > 0) && ($urandom_range(99) < valid_pct);
                if (src_q[i].size() > 0) begin
                    in_data[i*DW +: DW] = src_q[i][0].data;
                    in_last[i]          = src_q[i][0].last;
                end else begin
                    in_data[i*DW +: DW] = DW'($urandom);
                    in_last[i]          = 1'($urandom);
                end
            end
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            chk("out_valid", 64'(out_valid), 64'(m_ovalid));
            load_en = !m_ovalid || out_ready;
            exp_rdy = '0;
            sel     = -1;
            if (load_en) begin
                if (m_owner >= 0) begin
                    sel = m_owner;
                end else begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (in_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                    end
                end
                if (sel >= 0) exp_rdy[sel] = 1'b1;
            end
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            acc = (sel >= 0) && in_valid[sel];
            if (acc) begin
                b      = src_q[sel].pop_front();
                e.data = b.data;
                e.last = b.last;
                e.src  = IW'(sel);
                sb.push_back(e);
                if (b.last) begin
                    m_ptr   = (sel + 1) % N;
                    m_owner = -1;
                end else begin
                    m_owner = sel;
                end
            end
            m_ovalid = acc ? 1'b1 : (load_en ? 1'b0 : m_ovalid);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb.delete();
        m_ptr    = 0;
        m_owner  = -1;
        m_ovalid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        first_after_rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(0));
    endtask

    // Monitor: runs after the driver each cycle and retires beats that will be consumed.
    exp_t held;
    bit   prev_stall = 0;
    exp_t got;
    exp_t want;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            got.data = out_data;
            got.last = out_last;
            got.src  = out_src;
            if (!rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_hold", 64'(got), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual=unexpected beat %0h expected=none", got);
                    end else begin
                        want = sb.pop_front();
                        chk("beat", 64'(got), 64'(want));
                    end
                    if (first_after_rst) begin
                        chk("first_src_after_rst", 64'(out_src), 64'(0));
                        first_after_rst = 0;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held       = got;
            end
        end
    end

    initial begin
        do_reset();

        // Continuous single-beat packets from everyone: strict 0,1,2,3 rotation.
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 3; p++) add_packet(i, 1);
        end
        valid_pct = 100;
        ready_pct = 100;
        run_cycles(16);

        // Random multi-beat packets, random valid gaps and backpressure.
        refill    = 1;
        valid_pct = 70;
        ready_pct = 65;
        run_cycles(600);
        refill = 0;
        valid_pct = 100;
        ready_pct = 100;
        run_cycles(60);
        chk("drain_sb", 64'(sb.size()), 64'(0));

        // Lock onto requester 2 mid-packet, then reset; next grant must go to 0.
        add_packet(2, 5);
        run_cycles(3);
        do_reset();
        for (int i = 0; i < N; i++) add_packet(i, 2);
        run_cycles(20);
        chk("final_sb", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
